// File: rtl/program_loader.sv
// Host byte-stream loader: parses header/count/payload/checksum frames and drives
// the shared write port of the 16x8 instruction and data memories.
module program_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load,
    output logic       is_instruction,
    output logic [3:0] load_address,
    output logic [7:0] cpu_input,
    output logic       cpu_hold,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHECK   = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] addr_q;
    logic [3:0] remaining_q;
    logic [7:0] acc_q;

    logic       in_ready_q;
    logic       load_q;
    logic       is_instr_q;
    logic [3:0] load_address_q;
    logic [7:0] cpu_input_q;
    logic       cpu_hold_q;
    logic       done_q;
    logic       error_q;

    logic       xfer_s;

    // A byte moves only when the host offers it and we have left reset.
    assign xfer_s = in_valid & in_ready_q;

    assign in_ready       = in_ready_q;
    assign load           = load_q;
    assign is_instruction = is_instr_q;
    assign load_address   = load_address_q;
    assign cpu_input      = cpu_input_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;

    // Frame parser with registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= 4'd0;
            remaining_q    <= 4'd0;
            acc_q          <= 8'd0;
            in_ready_q     <= 1'b0;
            load_q         <= 1'b0;
            is_instr_q     <= 1'b0;
            load_address_q <= 4'd0;
            cpu_input_q    <= 8'd0;
            cpu_hold_q     <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            if (xfer_s) begin
                case (state_q)
                    S_IDLE: begin
                        if (in_data[6:4] != 3'b000) begin
                            error_q <= 1'b1;
                        end else begin
                            is_instr_q <= in_data[7];
                            addr_q     <= in_data[3:0];
                            cpu_hold_q <= 1'b1;
                            state_q    <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        remaining_q <= in_data[3:0];
                        acc_q       <= 8'd0;
                        state_q     <= S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        load_q         <= 1'b1;
                        load_address_q <= addr_q;
                        cpu_input_q    <= in_data;
                        acc_q          <= acc_q ^ in_data;
                        addr_q         <= addr_q + 4'd1;
                        if (remaining_q == 4'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            remaining_q <= remaining_q - 4'd1;
                        end
                    end
                    S_CHECK: begin
                        // Writes already issued stay in memory; only the status differs.
                        if (in_data == acc_q) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                    default: begin
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan plus
// random frames checked against a frame-level model of expected writes and status.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       load;
    logic       is_instruction;
    logic [3:0] load_address;
    logic [7:0] cpu_input;
    logic       cpu_hold;
    logic       done;
    logic       error;

    int         n_asserts = 0;
    int         n_fails   = 0;
    logic       cur_hold  = 1'b0;
    logic       exp_instr = 1'b0;
    logic [7:0] fr_pay [16];

    always #5 clk = ~clk;

    program_loader dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .load           (load),
        .is_instruction (is_instruction),
        .load_address   (load_address),
        .cpu_input      (cpu_input),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .error          (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 32'd0);
        chk({tag, "_load"}, load, 32'd0);
        chk({tag, "_is_instr"}, is_instruction, 32'd0);
        chk({tag, "_addr"}, load_address, 32'd0);
        chk({tag, "_data"}, cpu_input, 32'd0);
        chk({tag, "_hold"}, cpu_hold, 32'd0);
        chk({tag, "_done"}, done, 32'd0);
        chk({tag, "_error"}, error, 32'd0);
    endtask

    // One transfer, preceded by 'gap' cycles of in_valid = 0; checks outputs after each edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic e_load,
                             input logic [3:0] e_addr, input logic [7:0] e_data,
                             input logic e_done, input logic e_err, input logic e_hold);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("gap_load", load, 32'd0);
            chk("gap_done", done, 32'd0);
            chk("gap_error", error, 32'd0);
            chk("gap_hold", cpu_hold, 32'(cur_hold));
        end
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("load", load, 32'(e_load));
        if (e_load) begin
            chk("load_address", load_address, 32'(e_addr));
            chk("cpu_input", cpu_input, 32'(e_data));
        end
        chk("done", done, 32'(e_done));
        chk("error", error, 32'(e_err));
        chk("cpu_hold", cpu_hold, 32'(e_hold));
        chk("is_instruction", is_instruction, 32'(exp_instr));
        chk("in_ready", in_ready, 32'd1);
        cur_hold = e_hold;
    endtask

    // Frame-level model: payload i lands at (start + i) mod 16; checksum is XOR of payload.
    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] cnt,
                              input logic [7:0] cks, input int maxgap);
        int         n;
        logic [7:0] x;
        n = int'(cnt[3:0]) + 1;
        if (hdr[6:4] != 3'b000) begin
            send_byte(hdr, $urandom_range(maxgap, 0), 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
            return;
        end
        exp_instr = hdr[7];
        send_byte(hdr, $urandom_range(maxgap, 0), 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        send_byte(cnt, $urandom_range(maxgap, 0), 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            x = x ^ fr_pay[i];
            send_byte(fr_pay[i], $urandom_range(maxgap, 0), 1'b1, 4'(int'(hdr[3:0]) + i),
                      fr_pay[i], 1'b0, 1'b0, 1'b1);
        end
        send_byte(cks, $urandom_range(maxgap, 0), 1'b0, 4'd0, 8'd0,
                  (cks == x), (cks != x), 1'b0);
    endtask

    initial begin
        logic [7:0] hdr;
        logic [7:0] cnt;
        logic [7:0] x;
        int         n;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 32'd1);

        // Data load, no gaps.
        fr_pay[0] = 8'hAA; fr_pay[1] = 8'h55; fr_pay[2] = 8'h0F;
        send_frame(8'h03, 8'h02, 8'hF0, 0);

        // Instruction load wrapping past address 15, with valid gaps.
        fr_pay[0] = 8'h11; fr_pay[1] = 8'h22; fr_pay[2] = 8'h33; fr_pay[3] = 8'h44;
        send_frame(8'h8E, 8'h03, 8'h44, 1);

        // Bad checksum, then a good frame.
        fr_pay[0] = 8'h5A;
        send_frame(8'h00, 8'h00, 8'h00, 0);
        fr_pay[0] = 8'h12; fr_pay[1] = 8'h34;
        send_frame(8'h0A, 8'h01, 8'h26, 0);

        // Bad header, then the next byte is a header.
        send_frame(8'h10, 8'h00, 8'h00, 0);
        fr_pay[0] = 8'hC3;
        send_frame(8'h8F, 8'hF0, 8'hC3, 0);

        // Reset after two of four payload bytes.
        exp_instr = 1'b0;
        send_byte(8'h06, 0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h03, 0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA1, 0, 1'b1, 4'd6, 8'hA1, 1'b0, 1'b0, 1'b1);
        send_byte(8'hB2, 0, 1'b1, 4'd7, 8'hB2, 1'b0, 1'b0, 1'b1);
        reset    = 1'b1;
        in_data  = 8'hC3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        in_valid  = 1'b0;
        reset     = 1'b0;
        cur_hold  = 1'b0;
        exp_instr = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_ready", in_ready, 32'd1);
        chk("midreset_idle_load", load, 32'd0);
        fr_pay[0] = 8'h77;
        send_frame(8'h82, 8'h00, 8'h77, 0);

        // Full 16-byte frame at address 0.
        for (int i = 0; i < 16; i++) fr_pay[i] = 8'(i);
        send_frame(8'h00, 8'h0F, 8'h00, 0);

        // Random frames: random target/start/length/gaps, some bad headers and checksums.
        for (int f = 0; f < 40; f++) begin
            n   = $urandom_range(16, 1);
            hdr = {1'($urandom_range(1, 0)), 3'b000, 4'($urandom_range(15, 0))};
            if ($urandom_range(7, 0) == 0) hdr[6:4] = 3'($urandom_range(7, 1));
            cnt = {4'($urandom_range(15, 0)), 4'(n - 1)};
            x   = 8'd0;
            for (int i = 0; i < n; i++) begin
                fr_pay[i] = 8'($urandom_range(255, 0));
                x = x ^ fr_pay[i];
            end
            if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
            send_frame(hdr, cnt, x, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream loader that drives the memory load interface (load, is_instruction, load_address, cpu_input) shared by the 16×8 instruction and data memories. Host bytes arrive on a valid/ready stream and are framed as header, count, payload and checksum. The block writes the payload into consecutive addresses of the selected memory and holds the CPU while a frame is in progress. It sits between the external host port and the CPU memories, and is the only writer on the load interface.

## Interface
- No parameters. Widths are fixed by the 16-entry × 8-bit memories.
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  8  stream byte from host
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge
- load  output  1  one-cycle write strobe to memories
- is_instruction  output  1  1 = instruction memory target, 0 = data memory target
- load_address  output  4  write address
- cpu_input  output  8  write data
- cpu_hold  output  1  high while a frame is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse: frame completed, checksum good
- error  output  1  one-cycle pulse: frame rejected or checksum bad

## Operation
- Frame format:
  - Byte 0, header: bit7 = target (is_instruction), bits[6:4] must be 000, bits[3:0] = start address.
  - Byte 1, count: bits[3:0] = N−1, giving N payload bytes (1..16). Bits[7:4] are ignored.
  - Bytes 2..N+1: payload.
  - Byte N+2: checksum, equal to the XOR of all payload bytes.
- States:
  - IDLE: accepted byte is the header. If bits[6:4] ≠ 0, pulse error and stay in IDLE. Otherwise latch target and address, then go to COUNT.
  - COUNT: latch remaining = bits[3:0], clear the XOR accumulator, go to PAYLOAD.
  - PAYLOAD: each accepted byte issues one write, XORs into the accumulator and increments the address. After the byte with remaining = 0, go to CHECK; otherwise decrement remaining.
  - CHECK: compare the accepted byte with the accumulator. Match pulses done; mismatch pulses error. Either way go to IDLE.
- Address arithmetic is 4-bit and wraps: 15+1 = 0. A 16-byte frame starting at address 5 writes 5..15, then 0..4.
- Writes are not rolled back on a checksum error. error only flags the frame; the host reloads.
- Cycles with in_valid = 0 are idle cycles. State, counters and outputs are held, and load = 0.
- in_ready is 0 during reset and 1 in every state otherwise. The block never back-pressures after reset.
- Reset mid-frame: next state is IDLE, and no load occurs in the cycle after reset. Writes completed before reset stay in memory.

## Timing
- Reset values: in_ready = 0, load = 0, is_instruction = 0, load_address = 0, cpu_input = 0, cpu_hold = 0, done = 0, error = 0. State = IDLE.
- All outputs are registered.
- Payload byte accepted at edge E: at E, load = 1 with load_address and cpu_input valid, held for one cycle. The memory captures the byte at E+1. Latency is one cycle from acceptance to the write strobe.
- is_instruction is valid from the edge after the header and holds until the next header is accepted.
- cpu_hold rises at the edge that accepts a valid header. It falls at the edge that accepts the checksum, the same edge that asserts done or error.
- done and error are asserted at the edge accepting the checksum, or the bad header for error, and last exactly one cycle. They are never asserted together.
- Throughput: a frame of N bytes completes in N+3 accepted transfers. Back-to-back frames need no gap cycles.

## Test plan
- Data load, no gaps: stream 0x03, 0x02, 0xAA, 0x55, 0x0F, 0xF0. Expect three load pulses (addr 3 = 0xAA, addr 4 = 0x55, addr 5 = 0x0F), all with is_instruction = 0. Expect done pulsed on the checksum edge and cpu_hold high for 5 cycles.
- Instruction load with wrap and valid gaps: header 0x8E, count 0x03, payload 0x11, 0x22, 0x33, 0x44, checksum 0x44, with in_valid toggling. Expect writes to 14, 15, 0, 1 with is_instruction = 1, each exactly one cycle after acceptance, then done.
- Bad checksum: 0x00, 0x00, 0x5A, 0x00. Expect one write (addr 0 = 0x5A) and an error pulse, with done never asserted. A following valid frame loads normally.
- Bad header: 0x10. Expect an error pulse, no load, and cpu_hold staying 0. The next byte is parsed as a header.
- Reset mid-payload: assert reset after 2 of 4 payload bytes. Expect exactly 2 writes, all outputs at reset values the cycle after, and a new frame accepted after reset deasserts.
- Full 16-byte frame at address 0, payload 0x00..0x0F, checksum 0x00. Expect 16 writes to addresses 0..15 and done.
